// File: rtl/alu_sequencer.sv
// Command front-end for a registered ALU: queues opcode/operand commands, issues them one
// at a time, captures the ALU result and returns it over a valid/ready response port.
module alu_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  output logic [3:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 4 + 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  empty, full, push, pop;
  logic [EW-1:0]         head;
  logic [3:0]            head_op;
  logic [DATA_WIDTH-1:0] head_a, head_b;
  logic                  head_legal;

  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_op    = head[EW-1 -: 4];
  assign head_a     = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign head_b     = head[DATA_WIDTH-1:0];
  assign head_legal = (head_op[3:1] == 3'b000);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b};
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            state_d  = StIssue;
          end else begin
            // Illegal commands bypass the ALU so it never sees an undefined opcode.
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = StResp;
          end
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        rsp_result_d = alu_result;
        rsp_err_d    = 1'b0;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;
  assign alu_opcode    = alu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_result    = rsp_result_q;
  assign busy          = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural registered ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0] alu_opcode;
  logic       rsp_valid, rsp_ready, rsp_err, busy;
  logic [7:0] rsp_result;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q[$];  // {err, result}

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  // Registered ALU: add for 0000, subtract otherwise.
  initial alu_result = 8'h00;
  always @(posedge clk) begin
    alu_result <= (alu_opcode == 4'b0000) ? alu_operand_a + alu_operand_b
                                          : alu_operand_a - alu_operand_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {23'd0, rsp_err, rsp_result}, 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("rsp", {23'd0, rsp_err, rsp_result}, {23'd0, e});
      end
    end
  end

  // Called and returns at posedge+1; returns one edge after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [8:0] exp);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    int rv;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'h0;
    cmd_a      = 8'h00;
    cmd_b      = 8'h00;
    rsp_ready  = 1'b1;
    step(); step();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_outputs", {rsp_valid, rsp_err, rsp_result, alu_opcode, alu_operand_a,
                          alu_operand_b}, 32'd0);
    check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Add with latency check.
    send(4'b0000, 8'h05, 8'h03, {1'b0, 8'h08});
    check("add_lat_e0", {31'd0, rsp_valid}, 32'd0);
    step();
    check("add_lat_e1", {31'd0, rsp_valid}, 32'd0);
    step();
    check("add_lat_e2", {31'd0, rsp_valid}, 32'd0);
    step();
    check("add_lat_e3", {31'd0, rsp_valid}, 32'd1);
    check("add_result", {24'd0, rsp_result}, 32'h08);
    check("add_err", {31'd0, rsp_err}, 32'd0);
    step();
    check("add_drop", {31'd0, rsp_valid}, 32'd0);
    wait_idle("add");

    // Modular wrap, in order.
    send(4'b0001, 8'h02, 8'h05, {1'b0, 8'hFD});
    send(4'b0000, 8'hFF, 8'h01, {1'b0, 8'h00});
    wait_idle("wrap");

    // Illegal opcode: response one edge after pop, ALU regs untouched.
    send(4'b0111, 8'h11, 8'h22, {1'b1, 8'h00});
    step();
    check("ill_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill_err", {31'd0, rsp_err}, 32'd1);
    check("ill_result", {24'd0, rsp_result}, 32'h00);
    check("ill_alu_regs", {12'd0, alu_opcode, alu_operand_a, alu_operand_b}, 32'h0_FF01);
    wait_idle("ill");

    // Backpressure: one command parks in RESP, four fill the FIFO, sixth is refused.
    rsp_ready = 1'b0;
    send(4'b0000, 8'h01, 8'h02, {1'b0, 8'h03});
    send(4'b0001, 8'h10, 8'h01, {1'b0, 8'h0F});
    send(4'b1111, 8'hAA, 8'h55, {1'b1, 8'h00});
    send(4'b0000, 8'h80, 8'h80, {1'b0, 8'h00});
    send(4'b0001, 8'h00, 8'h01, {1'b0, 8'hFF});
    cmd_valid  = 1'b1;
    cmd_opcode = 4'b0000;
    cmd_a      = 8'h77;
    cmd_b      = 8'h77;
    check("bp_full", {31'd0, cmd_ready}, 32'd0);
    step(); step(); step();
    check("bp_still_full", {31'd0, cmd_ready}, 32'd0);
    check("bp_held_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_held_result", {24'd0, rsp_result}, 32'h03);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("bp");
    for (int i = 0; i < 8; i++) step();
    check("bp_no_extra", {31'd0, busy}, 32'd0);

    // Reset during CAPTURE of a queued burst.
    send(4'b0000, 8'h40, 8'h01, {1'b0, 8'h41});
    send(4'b0000, 8'h02, 8'h02, {1'b0, 8'h04});
    send(4'b0001, 8'h09, 8'h03, {1'b0, 8'h06});
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_outputs", {rsp_valid, rsp_err, rsp_result, alu_opcode, alu_operand_a,
                              alu_operand_b}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) rv++;
    end
    check("post_rst_no_rsp", rv, 32'd0);
    send(4'b0000, 8'h21, 8'h12, {1'b0, 8'h33});
    wait_idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
